fetch_wb: RTL and testbench
===========================

Name: fetch_wb

Overview:
- Instruction-fetch Wishbone master that sits directly upstream of the on-chip ROM slave.
- Issues single-word classic Wishbone reads at a sequential fetch PC and buffers the returned words, each with its PC, in a small FIFO.
- Presents the FIFO head to the CPU decode stage over a valid/ready handshake.
- Supports a PC redirect (branch/jump) that flushes the buffer and safely discards any in-flight bus read.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
FIFO_DEPTH, 4, prefetch buffer entries; power of two, minimum 2.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
wbm_cyc_o  output  1  Wishbone cycle.
wbm_stb_o  output  1  Wishbone strobe; always equal to wbm_cyc_o.
wbm_adr_o  output  32  byte address, word aligned.
wbm_ack_i  input  1  slave acknowledge.
wbm_dat_i  input  32  read data, valid when wbm_ack_i is high.
redirect_i  input  1  load a new fetch PC and flush the buffer.
redirect_pc_i  input  32  new PC; bits [1:0] are ignored and forced to 0.
inst_valid_o  output  1  FIFO head is valid.
inst_data_o  output  32  FIFO head instruction word.
inst_pc_o  output  32  FIFO head PC.
inst_ready_i  input  1  consumer accepts the head this cycle.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high. All state registers use it.
- Reset values:
  - wbm_cyc_o = 0, wbm_stb_o = 0, wbm_adr_o = RESET_PC.
  - fetch_pc = RESET_PC, FIFO empty, inst_valid_o = 0.
  - inst_data_o and inst_pc_o = 0 while the FIFO is empty.
- All Wishbone outputs are registered.
- Bus timing: wbm_cyc_o, wbm_stb_o and wbm_adr_o are held stable until wbm_ack_i. At most one read is outstanding. The ROM acks one cycle after the strobe, so sustained throughput is one word per 2 cycles.
- State machine with states IDLE, REQ and DRAIN:
  - IDLE: bus idle. Move to REQ when FIFO occupancy after this cycle's pop is less than FIFO_DEPTH. Assert cyc/stb with adr = fetch_pc on the next edge. wbm_ack_i is ignored in IDLE.
  - REQ, ack without redirect: push {wbm_adr_o, wbm_dat_i} and set fetch_pc += 4. If occupancy after push and pop is less than FIFO_DEPTH, stay in REQ with adr = new fetch_pc and cyc/stb kept high. Otherwise go to IDLE and drop cyc/stb.
  - REQ, redirect without ack: flush the FIFO and set fetch_pc = redirect_pc_i. Go to DRAIN, keeping cyc/stb/adr unchanged.
  - REQ, redirect and ack in the same cycle: discard the data, flush, set fetch_pc = redirect_pc_i, stay in REQ with adr = redirect PC.
  - DRAIN: wait for wbm_ack_i, then discard the data and go to REQ with adr = fetch_pc. A further redirect in DRAIN only updates fetch_pc; the newest redirect wins.
  - IDLE, redirect: flush, load fetch_pc, go to REQ.
- FIFO and handshake:
  - inst_valid_o = (count != 0). inst_data_o and inst_pc_o come from the head entry.
  - A pop occurs when inst_valid_o && inst_ready_i. Push and pop in the same cycle keep count unchanged.
  - Redirect has priority: a pop in the redirect cycle is ignored and inst_valid_o is 0 on the next cycle.
  - Overflow is impossible because a request is only issued or continued with a free slot reserved. Underflow is impossible because a pop requires valid.
- fetch_pc increments modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- First-word latency: rst falls before edge E0. cyc/stb rise after E0, the ROM acks after E1, and inst_valid_o rises after E2.
- Reset mid-transfer aborts immediately: cyc/stb go low, the FIFO empties, and any late ack arrives in IDLE and is ignored.

Test Plan:
- Reset with RESET_PC = 0 and inst_ready_i = 1 -> words from addresses 0x0, 0x4, 0x8 are delivered in order with inst_pc_o matching. The first inst_valid_o rises 3 edges after reset release. One word is delivered every 2 cycles in steady state.
- inst_ready_i held 0 -> exactly FIFO_DEPTH = 4 reads are issued (0x0..0xC), then cyc/stb drop. Releasing ready drains 4 words in 4 consecutive cycles, and fetch resumes at 0x10.
- Redirect to 0x100 while in REQ one cycle before the ack -> the old data is discarded and the FIFO is empty. The next bus address is 0x100, and the first delivered pc is 0x100.
- Redirect to 0x200 in the same cycle as ack and pop -> the pop is ignored and the acked word is not delivered. The next adr is 0x200, and no stale pc ever appears at the output.
- Two redirects during DRAIN (0x300, then 0x400) -> a single in-flight ack is discarded, and the next request address is 0x400.
- rst asserted while cyc is high and again with the FIFO half full -> all outputs return to reset values asynchronously, the late ack is ignored, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_wb_if.sv
// rtl/fetch_wb_if.sv - Wishbone fetch bus and instruction stream bundle
//
// Groups every non-clock signal of the fetch unit:
//   wbm_*        classic Wishbone read master towards the ROM
//   redirect_*   branch/jump redirect from the core
//   inst_*       valid/ready instruction stream towards decode
// modport master : the fetch unit side
// modport slave  : the environment side (ROM + core)
interface fetch_wb_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_adr_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_data_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_adr_o,
    input  wbm_ack_i, wbm_dat_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_data_o, inst_pc_o,
    input  inst_ready_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_adr_o,
    output wbm_ack_i, wbm_dat_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_data_o, inst_pc_o,
    output inst_ready_i
  );
endinterface

// File: rtl/fetch_wb.sv
// rtl/fetch_wb.sv - instruction-fetch Wishbone master with prefetch FIFO
//
// Issues single-word Wishbone reads at a sequential fetch PC, buffers each
// returned word together with its PC, and presents the buffer head to decode.
// A redirect flushes the buffer and discards any in-flight read.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  fetch_wb_if.master (Wishbone master, redirect, instruction stream)
module fetch_wb #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fetch_wb_if.master  bus
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            cyc_q, cyc_d;
  logic [31:0]     adr_q, adr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     data_q [FIFO_DEPTH];
  logic [31:0]     data_d [FIFO_DEPTH];
  logic [31:0]     pc_q   [FIFO_DEPTH];
  logic [31:0]     pc_d   [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push;
  logic            pop;
  logic [CW-1:0]   count_next;
  logic [31:0]     redirect_pc;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^bus.redirect_pc_i[1:0];

  always_comb begin
    redirect_pc = {bus.redirect_pc_i[31:2], 2'b00};
    // Redirect overrides both sides of the FIFO: the acked word is dropped
    // and the consumer's pop is ignored.
    push = (state_q == REQ) && bus.wbm_ack_i && !bus.redirect_i;
    pop  = (count_q != '0) && bus.inst_ready_i && !bus.redirect_i;

    // Occupancy after this cycle's push/pop; a request is issued or kept
    // only while this leaves a free slot for the word it will return.
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CW'(1);
    end else if (!push && pop) begin
      count_next = count_q - CW'(1);
    end

    state_d    = state_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    fetch_pc_d = fetch_pc_q;
    data_d     = data_q;
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_next;

    if (bus.redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = bus.wbm_dat_i;
        pc_d[wr_ptr_q]   = adr_q;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        // Acks seen here belong to a read aborted by reset; ignore them.
        if (bus.redirect_i) begin
          fetch_pc_d = redirect_pc;
          state_d    = REQ;
          cyc_d      = 1'b1;
          adr_d      = redirect_pc;
        end else if (count_next < DEPTH_CNT) begin
          state_d = REQ;
          cyc_d   = 1'b1;
          adr_d   = fetch_pc_q;
        end
      end
      REQ: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redirect_pc;
          if (bus.wbm_ack_i) begin
            adr_d = redirect_pc;
          end else begin
            // Read cannot be withdrawn; hold the bus until its ack.
            state_d = DRAIN;
          end
        end else if (bus.wbm_ack_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_next < DEPTH_CNT) begin
            adr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = IDLE;
            cyc_d   = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (bus.redirect_i) begin
          fetch_pc_d = redirect_pc;
        end
        if (bus.wbm_ack_i) begin
          state_d = REQ;
          adr_d   = bus.redirect_i ? redirect_pc : fetch_pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      adr_q      <= RESET_PC_W;
      fetch_pc_q <= RESET_PC_W;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

  assign bus.wbm_cyc_o    = cyc_q;
  assign bus.wbm_stb_o    = cyc_q;
  assign bus.wbm_adr_o    = adr_q;
  assign bus.inst_valid_o = (count_q != '0);
  assign bus.inst_data_o  = (count_q != '0) ? data_q[rd_ptr_q] : 32'h0;
  assign bus.inst_pc_o    = (count_q != '0) ? pc_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_wb.sv
// tb/tb_fetch_wb.sv - directed self-checking bench for fetch_wb
`timescale 1ns/1ps
module tb_fetch_wb;

  logic        clk;
  logic        rst;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_dat = 32'h0;
  logic        rom_hold;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;
  int          cyc_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_dat[$];
  int          got_cyc[$];
  logic [31:0] ack_adr[$];

  fetch_wb_if bus();

  assign bus.wbm_ack_i     = rom_ack;
  assign bus.wbm_dat_i     = rom_dat;
  assign bus.redirect_i    = redirect;
  assign bus.redirect_pc_i = redirect_pc;
  assign bus.inst_ready_i  = ready;

  fetch_wb #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hA5C3_1E00;
  endfunction

  // ROM: registered ack one cycle after strobe, never back-to-back.
  always @(posedge clk) begin
    rom_ack <= bus.wbm_cyc_o && bus.wbm_stb_o && !rom_ack && !rom_hold;
    rom_dat <= rom_word(bus.wbm_adr_o);
    cyc_cnt <= cyc_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    rom_hold = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic collect(input int n, input int bound);
    got_pc.delete();
    got_dat.delete();
    got_cyc.delete();
    for (int i = 0; i < bound && got_pc.size() < n; i++) begin
      if (bus.inst_valid_o && ready) begin
        got_pc.push_back(bus.inst_pc_o);
        got_dat.push_back(bus.inst_data_o);
        got_cyc.push_back(cyc_cnt);
      end
      step();
    end
  endtask

  task automatic check_collected(input string name, input logic [31:0] first_pc, input int n);
    checks++;
    if (got_pc.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d words, expected %0d", name, got_pc.size(), n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= got_pc.size()) begin
        errors++;
        $display("FAIL %s_pc%0d: got none, expected %h", name, i, first_pc + 32'(4 * i));
      end else if (got_pc[i] !== first_pc + 32'(4 * i) ||
                   got_dat[i] !== rom_word(first_pc + 32'(4 * i))) begin
        errors++;
        $display("FAIL %s_word%0d: got pc %h data %h, expected pc %h data %h", name, i,
                 got_pc[i], got_dat[i], first_pc + 32'(4 * i), rom_word(first_pc + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.wbm_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got cyc %b stb %b adr %h, expected 0 0 00000000",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o);
    end
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.inst_data_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_inst: got valid %b data %h pc %h, expected 0 0 0",
               bus.inst_valid_o, bus.inst_data_o, bus.inst_pc_o);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h0 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL first_req: got cyc %b adr %h valid %b, expected 1 00000000 0",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.inst_valid_o);
    end
    step();
    checks++;
    if (bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: got %b, expected 0", bus.inst_valid_o);
    end
    step();
    checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL first_valid: got valid %b pc %h, expected 1 00000000",
               bus.inst_valid_o, bus.inst_pc_o);
    end
    collect(3, 20);
    check_collected("stream", 32'h0, 3);
    checks++;
    if (got_cyc.size() != 3 || got_cyc[1] - got_cyc[0] != 2 || got_cyc[2] - got_cyc[1] != 2) begin
      errors++;
      $display("FAIL throughput: got %0d words with gaps not all 2, expected 2-cycle spacing",
               got_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b0;
    do_reset();
    ack_adr.delete();
    for (int i = 0; i < 30; i++) begin
      if (bus.wbm_cyc_o && rom_ack) ack_adr.push_back(bus.wbm_adr_o);
      step();
    end
    checks++;
    if (ack_adr.size() != 4) begin
      errors++;
      $display("FAIL bp_reads: got %0d reads, expected 4", ack_adr.size());
    end
    for (int i = 0; i < 4 && i < ack_adr.size(); i++) begin
      checks++;
      if (ack_adr[i] !== 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_adr%0d: got %h, expected %h", i, ack_adr[i], 32'(4 * i));
      end
    end
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle: got cyc %b stb %b, expected 0 0", bus.wbm_cyc_o, bus.wbm_stb_o);
    end
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_drain%0d: got valid %b pc %h, expected 1 %h", i,
                 bus.inst_valid_o, bus.inst_pc_o, 32'(4 * i));
      end
      step();
    end
    collect(1, 20);
    check_collected("bp_resume", 32'h10, 1);
  endtask

  task automatic test_redirect_req();
    logic [31:0] old_adr;
    ready = 1'b1;
    rom_hold = 1'b1;
    for (int i = 0; i < 10 && !(bus.wbm_cyc_o && !rom_ack); i++) step();
    old_adr = bus.wbm_adr_o;
    redirect_pc = 32'h100;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== old_adr) begin
      errors++;
      $display("FAIL rdq_drain: got valid %b cyc %b adr %h, expected 0 1 %h",
               bus.inst_valid_o, bus.wbm_cyc_o, bus.wbm_adr_o, old_adr);
    end
    rom_hold = 1'b0;
    step();
    step();
    checks++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h100 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rdq_newadr: got cyc %b adr %h valid %b, expected 1 00000100 0",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.inst_valid_o);
    end
    collect(2, 20);
    check_collected("rdq", 32'h100, 2);
  endtask

  task automatic test_redirect_ack();
    ready = 1'b0;
    for (int i = 0; i < 20 && !(bus.inst_valid_o && rom_ack); i++) step();
    checks++;
    if (!(bus.inst_valid_o && rom_ack)) begin
      errors++;
      $display("FAIL rda_setup: got valid %b ack %b, expected 1 1", bus.inst_valid_o, rom_ack);
    end
    redirect_pc = 32'h200;
    redirect = 1'b1;
    ready = 1'b1;
    step();
    redirect = 1'b0;
    checks++;
    if (bus.inst_valid_o !== 1'b0 || bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h200) begin
      errors++;
      $display("FAIL rda_after: got valid %b cyc %b adr %h, expected 0 1 00000200",
               bus.inst_valid_o, bus.wbm_cyc_o, bus.wbm_adr_o);
    end
    collect(3, 20);
    check_collected("rda", 32'h200, 3);
  endtask

  task automatic test_drain_redirects();
    logic [31:0] old_adr;
    ready = 1'b1;
    rom_hold = 1'b1;
    for (int i = 0; i < 10 && !(bus.wbm_cyc_o && !rom_ack); i++) step();
    old_adr = bus.wbm_adr_o;
    redirect_pc = 32'h300;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    step();
    redirect_pc = 32'h403;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    checks++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== old_adr || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drn_hold: got cyc %b adr %h valid %b, expected 1 %h 0",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.inst_valid_o, old_adr);
    end
    rom_hold = 1'b0;
    step();
    step();
    checks++;
    if (bus.wbm_adr_o !== 32'h400 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drn_newadr: got adr %h valid %b, expected 00000400 0",
               bus.wbm_adr_o, bus.inst_valid_o);
    end
    collect(2, 20);
    check_collected("drn", 32'h400, 2);
  endtask

  task automatic test_reset_midflight();
    int acks;
    ready = 1'b1;
    for (int i = 0; i < 10 && !(bus.wbm_cyc_o && rom_ack); i++) step();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_stb_o !== 1'b0 || bus.wbm_adr_o !== 32'h0 ||
        bus.inst_valid_o !== 1'b0 || bus.inst_pc_o !== 32'h0 || bus.inst_data_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_async1: got cyc %b stb %b adr %h valid %b pc %h data %h, expected all 0",
               bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.inst_valid_o,
               bus.inst_pc_o, bus.inst_data_o);
    end
    #2;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.wbm_cyc_o !== 1'b1 || bus.wbm_adr_o !== 32'h0 || bus.inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_lateack: got cyc %b adr %h valid %b, expected 1 00000000 0",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.inst_valid_o);
    end
    collect(1, 20);
    check_collected("rst_restart1", 32'h0, 1);

    ready = 1'b0;
    do_reset();
    acks = 0;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      if (rom_ack) acks++;
      step();
    end
    checks++;
    if (bus.inst_valid_o !== 1'b1 || bus.inst_pc_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_half: got valid %b pc %h, expected 1 00000000",
               bus.inst_valid_o, bus.inst_pc_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wbm_cyc_o !== 1'b0 || bus.wbm_adr_o !== 32'h0 || bus.inst_valid_o !== 1'b0 ||
        bus.inst_pc_o !== 32'h0 || bus.inst_data_o !== 32'h0) begin
      errors++;
      $display("FAIL rst_async2: got cyc %b adr %h valid %b pc %h data %h, expected all 0",
               bus.wbm_cyc_o, bus.wbm_adr_o, bus.inst_valid_o, bus.inst_pc_o, bus.inst_data_o);
    end
    #2;
    rst = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    collect(2, 20);
    check_collected("rst_restart2", 32'h0, 2);
  endtask

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    rom_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_backpressure();
    test_redirect_req();
    test_redirect_ack();
    test_drain_redirects();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
